// File: rtl/hwpe_stream_tcdm_load_arbiter_if.sv
// hwpe_stream_tcdm_load_arbiter_if: requester-side load bundle plus the shared TCDM read port.
interface hwpe_stream_tcdm_load_arbiter_if #(parameter int NB_IN = 4);
  logic [NB_IN-1:0]    in_req;
  logic [NB_IN*32-1:0] in_add;
  logic [NB_IN-1:0]    in_gnt;
  logic [NB_IN-1:0]    in_r_valid;
  logic [31:0]         in_r_data;
  logic                out_req;
  logic [31:0]         out_add;
  logic                out_wen;
  logic [3:0]          out_be;
  logic [31:0]         out_data;
  logic                out_gnt;
  logic                out_r_valid;
  logic [31:0]         out_r_data;
  modport slave (
    input  in_req, in_add, out_gnt, out_r_valid, out_r_data,
    output in_gnt, in_r_valid, in_r_data, out_req, out_add, out_wen, out_be, out_data
  );
  modport master (
    output in_req, in_add, out_gnt, out_r_valid, out_r_data,
    input  in_gnt, in_r_valid, in_r_data, out_req, out_add, out_wen, out_be, out_data
  );
endinterface

// File: rtl/hwpe_stream_tcdm_load_arbiter.sv
// hwpe_stream_tcdm_load_arbiter: round-robin share of one TCDM load port with in-order response steering.
module hwpe_stream_tcdm_load_arbiter #(
  parameter int NB_IN           = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  hwpe_stream_tcdm_load_arbiter_if.slave bus,
  output logic busy_o,
  output logic err_o
);
  localparam int ID_W  = $clog2(NB_IN);
  localparam int QA_W  = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = QA_W + 1;
  logic [ID_W-1:0]  ptr, w;
  logic [CNT_W-1:0] cnt;
  logic [QA_W-1:0]  wr, rd;
  logic [ID_W-1:0]  fifo [MAX_OUTSTANDING];
  logic             any, hs, rsp;
  always_comb begin
    w = '0;
    for (int k = NB_IN - 1; k >= 0; k--)
      if (bus.in_req[(int'(ptr) + k) % NB_IN]) w = ID_W'((int'(ptr) + k) % NB_IN);
  end
  assign any            = |bus.in_req;
  // issue is gated by the registered count, so a full queue costs one bubble even if a response lands
  assign bus.out_req    = any & (cnt < CNT_W'(MAX_OUTSTANDING));
  assign bus.out_add    = any ? bus.in_add[32*w +: 32] : '0;
  assign bus.out_wen    = 1'b1;
  assign bus.out_be     = 4'hF;
  assign bus.out_data   = '0;
  assign hs             = bus.out_req & bus.out_gnt;
  assign busy_o         = cnt != '0;
  assign rsp            = bus.out_r_valid & busy_o;
  assign bus.in_gnt     = hs ? NB_IN'(1) << w : '0;
  assign bus.in_r_valid = (rsp & ~clear_i) ? NB_IN'(1) << fifo[rd] : '0;
  assign bus.in_r_data  = bus.out_r_data;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr   <= '0;
      cnt   <= '0;
      wr    <= '0;
      rd    <= '0;
      err_o <= 1'b0;
    end else if (clear_i) begin
      ptr   <= '0;
      cnt   <= '0;
      wr    <= '0;
      rd    <= '0;
      err_o <= 1'b0;
    end else begin
      if (hs) begin
        ptr <= (w == ID_W'(NB_IN - 1)) ? '0 : w + 1'b1;
        wr  <= wr + 1'b1;
      end
      if (rsp) rd <= rd + 1'b1;
      if (bus.out_r_valid & ~busy_o) err_o <= 1'b1;
      cnt <= cnt + CNT_W'(hs) - CNT_W'(rsp);
    end
  end
  always_ff @(posedge clk_i)
    if (hs & ~clear_i) fifo[wr] <= w;
endmodule

// File: tb/tb_hwpe_stream_tcdm_load_arbiter.sv
// tb_hwpe_stream_tcdm_load_arbiter: directed table, corner sequences and random traffic against a queue model.
module tb_hwpe_stream_tcdm_load_arbiter;
  localparam int N  = 4;
  localparam int MO = 4;
  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
  logic busy, err;
  hwpe_stream_tcdm_load_arbiter_if #(.NB_IN(N)) bus ();
  hwpe_stream_tcdm_load_arbiter #(.NB_IN(N), .MAX_OUTSTANDING(MO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .bus(bus), .busy_o(busy), .err_o(err)
  );
  always #5 clk = ~clk;
  int n_vec = 0, n_err = 0;
  int ptr = 0;
  int q[$];
  bit m_err = 0;
  logic [31:0] addr [N];
  typedef struct {
    logic [N-1:0] req;
    logic         gnt;
    logic         rv;
    logic [31:0]  rdata;
    logic [N-1:0] e_gnt;
    logic [N-1:0] e_rv;
    logic         e_busy;
    logic         e_err;
  } vec_t;
  vec_t tbl [8];
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(logic [N-1:0] req, logic gnt, logic rv, logic [31:0] rdata, logic clr);
    bus.in_req = req;
    bus.out_gnt = gnt;
    bus.out_r_valid = rv;
    bus.out_r_data = rdata;
    clear = clr;
    for (int i = 0; i < N; i++) bus.in_add[32*i +: 32] = addr[i];
  endtask
  task automatic model_reset();
    q.delete();
    ptr = 0;
    m_err = 0;
  endtask
  // one clock: check every output against the model, then advance the model at the edge
  task automatic cycle();
    int w;
    bit f, e_req, h, clr, rv, g;
    logic [N-1:0] e_gnt, e_rv;
    logic [31:0] e_add;
    #1;
    w = 0;
    f = 0;
    for (int k = 0; k < N; k++)
      if (!f && bus.in_req[(ptr + k) % N]) begin
        w = (ptr + k) % N;
        f = 1;
      end
    e_req = f && (q.size() < MO);
    e_add = f ? addr[w] : 32'h0;
    e_gnt = '0;
    if (e_req && bus.out_gnt) e_gnt[w] = 1'b1;
    h = q.size() > 0;
    e_rv = '0;
    if (bus.out_r_valid && h && !clear) e_rv[q[0]] = 1'b1;
    chk("out_req", {31'b0, bus.out_req}, {31'b0, e_req});
    chk("out_add", bus.out_add, e_add);
    chk("in_gnt", {28'b0, bus.in_gnt}, {28'b0, e_gnt});
    chk("in_r_valid", {28'b0, bus.in_r_valid}, {28'b0, e_rv});
    chk("in_r_data", bus.in_r_data, bus.out_r_data);
    chk("busy", {31'b0, busy}, {31'b0, h});
    chk("err", {31'b0, err}, {31'b0, m_err});
    chk("consts", {bus.out_wen, bus.out_be, bus.out_data[26:0]}, {1'b1, 4'hF, 27'h0});
    clr = clear;
    rv = bus.out_r_valid;
    g = bus.out_gnt;
    @(posedge clk);
    if (clr) model_reset();
    else begin
      if (rv) begin
        if (h) void'(q.pop_front());
        else m_err = 1;
      end
      if (e_req && g) begin
        q.push_back(w);
        ptr = (w + 1) % N;
      end
    end
    @(negedge clk);
  endtask
  initial begin
    for (int i = 0; i < N; i++) addr[i] = 32'h100 * (i + 1);
    tbl[0] = '{4'b0001, 1, 0, 32'h0,        4'b0001, 4'b0000, 0, 0};
    tbl[1] = '{4'b0000, 1, 1, 32'hDEADBEEF, 4'b0000, 4'b0001, 1, 0};
    tbl[2] = '{4'b0000, 0, 0, 32'h0,        4'b0000, 4'b0000, 0, 0};
    tbl[3] = '{4'b1111, 1, 0, 32'h0,        4'b0010, 4'b0000, 0, 0};
    tbl[4] = '{4'b1111, 1, 1, 32'h11111111, 4'b0100, 4'b0010, 1, 0};
    tbl[5] = '{4'b1111, 0, 1, 32'h22222222, 4'b0000, 4'b0100, 1, 0};
    tbl[6] = '{4'b0000, 0, 1, 32'h33333333, 4'b0000, 4'b0000, 0, 0};
    tbl[7] = '{4'b0000, 0, 0, 32'h0,        4'b0000, 4'b0000, 0, 1};
    drive('0, 0, 0, 0, 0);
    #1;
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_err", {31'b0, err}, 32'h0);
    chk("reset_out_req", {31'b0, bus.out_req}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].req, tbl[i].gnt, tbl[i].rv, tbl[i].rdata, 0);
      #1;
      chk($sformatf("tbl%0d_gnt", i), {28'b0, bus.in_gnt}, {28'b0, tbl[i].e_gnt});
      chk($sformatf("tbl%0d_rv", i), {28'b0, bus.in_r_valid}, {28'b0, tbl[i].e_rv});
      chk($sformatf("tbl%0d_data", i), bus.in_r_data, tbl[i].rdata);
      chk($sformatf("tbl%0d_busy", i), {31'b0, busy}, {31'b0, tbl[i].e_busy});
      chk($sformatf("tbl%0d_err", i), {31'b0, err}, {31'b0, tbl[i].e_err});
      cycle();
    end
    drive('0, 0, 0, 0, 1);
    cycle();
    drive('0, 0, 0, 0, 0);
    #1;
    chk("clear_err", {31'b0, err}, 32'h0);
    cycle();
    // all requesters, one-cycle responses: strict rotation
    for (int i = 0; i < 100; i++) begin
      drive(4'b1111, 1, i > 0, $urandom, 0);
      #1;
      chk("rot_gnt", {28'b0, bus.in_gnt}, 32'h1 << (i % N));
      cycle();
    end
    drive('0, 0, 1, 32'hAA, 0);
    cycle();
    // fill the ID queue with responses withheld, then release one
    for (int i = 0; i < MO; i++) begin
      drive(4'b1111, 1, 0, 0, 0);
      cycle();
    end
    drive(4'b1111, 1, 0, 0, 0);
    #1;
    chk("full_out_req", {31'b0, bus.out_req}, 32'h0);
    cycle();
    drive(4'b1111, 1, 1, 32'h55, 0);
    #1;
    chk("bubble_out_req", {31'b0, bus.out_req}, 32'h0);
    cycle();
    drive(4'b1111, 1, 0, 0, 0);
    #1;
    chk("reissue_out_req", {31'b0, bus.out_req}, 32'h1);
    cycle();
    drive('0, 0, 0, 0, 1);
    cycle();
    // requester 2 stalls on gnt=0 while 3 also asks
    for (int i = 0; i < 5; i++) begin
      drive(4'b1100, 0, 0, 0, 0);
      #1;
      chk("stall_add", bus.out_add, addr[2]);
      cycle();
    end
    drive(4'b1100, 1, 0, 0, 0);
    #1;
    chk("stall_gnt2", {28'b0, bus.in_gnt}, 32'h4);
    cycle();
    drive(4'b1100, 1, 0, 0, 0);
    #1;
    chk("stall_gnt3", {28'b0, bus.in_gnt}, 32'h8);
    cycle();
    drive('0, 0, 0, 0, 1);
    cycle();
    // async reset with three outstanding, then late responses count as spurious
    for (int i = 0; i < 3; i++) begin
      drive(4'b0111, 1, 0, 0, 0);
      cycle();
    end
    drive('0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'h0);
    chk("arst_err", {31'b0, err}, 32'h0);
    chk("arst_out_req", {31'b0, bus.out_req}, 32'h0);
    chk("arst_rv", {28'b0, bus.in_r_valid}, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive('0, 0, 1, 32'h77, 0);
    cycle();
    drive('0, 0, 0, 0, 0);
    #1;
    chk("late_rsp_err", {31'b0, err}, 32'h1);
    cycle();
    drive('0, 0, 0, 0, 1);
    cycle();
    for (int i = 0; i < 400; i++) begin
      for (int j = 0; j < N; j++) addr[j] = $urandom;
      drive(N'($urandom), ($urandom % 4) != 0,
            (q.size() > 0) ? ($urandom % 2 == 1) : ($urandom % 40 == 0),
            $urandom, $urandom % 60 == 0);
      cycle();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/hwpe_stream_tcdm_load_arbiter.md
Name: hwpe_stream_tcdm_load_arbiter

Overview:
- Shares one TCDM load port between NB_IN load requesters. Each requester is a load-FIFO slave side.
- Uses round-robin arbitration on the request channel.
- Records the winner's index in an in-order ID queue and steers each returning r_valid/r_data back to the requester that issued it.
- Sits between several HWPE load streamers and a single TCDM master port.

Parameters:
NB_IN, 4, number of requesters (2..16)
MAX_OUTSTANDING, 4, max granted-but-unanswered requests; depth of the ID queue (power of two, >=2)
ID_W, $clog2(NB_IN), width of the stored requester index (derived, not overridable)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
clear_i  in  1  synchronous soft clear
in_req_i  in  NB_IN  per-requester request
in_add_i  in  NB_IN*32  per-requester word address; slice i = bits [32*i+31:32*i]
in_gnt_o  out  NB_IN  per-requester grant, one-hot or zero
in_r_valid_o  out  NB_IN  per-requester response valid, one-hot or zero
in_r_data_o  out  32  response data, shared by all requesters
out_req_o  out  1  TCDM request
out_add_o  out  32  TCDM address
out_wen_o  out  1  constant 1 (read)
out_be_o  out  4  constant 4'hF
out_data_o  out  32  constant 0
out_gnt_i  in  1  TCDM grant
out_r_valid_i  in  1  TCDM response valid, in order, arbitrary latency >=1 cycle after gnt
out_r_data_i  in  32  TCDM response data
busy_o  out  1  outstanding count nonzero
err_o  out  1  sticky: response received with empty ID queue

Behaviour:
- Reset (rst_ni=0, async): round-robin pointer=0, outstanding count=0, ID queue empty, err_o=0. All outputs are then 0 except the constants out_wen_o, out_be_o and out_data_o.
- clear_i=1 at a clock edge: same state as reset. Responses arriving in that cycle are dropped, not forwarded.
- Arbitration (combinational):
  - Winner w = first i with in_req_i[i]=1, scanning from the pointer upward and wrapping modulo NB_IN.
  - can_issue = (count < MAX_OUTSTANDING).
  - out_req_o = |in_req_i & can_issue. out_add_o = in_add_i slice w; 0 when no request is pending.
  - in_gnt_o[w] = out_gnt_i & out_req_o. All other bits are 0.
- Grant handshake (out_req_o & out_gnt_i):
  - Push w into the ID queue.
  - Pointer <= (w+1) mod NB_IN.
- No handshake: pointer is held. A requester keeping req high stays the winner until granted, so addr/req stay stable for the TCDM.
- Response steering:
  - On out_req_o... correction not needed: on out_r_valid_i=1 with queue non-empty, in_r_valid_o[head]=1, in_r_data_o=out_r_data_i, then pop the head.
  - in_r_data_o passes out_r_data_i through at all times.
  - Responses cannot be back-pressured; requesters must accept every cycle.
- Count update per edge: +1 on grant only, -1 on response only, unchanged when both happen in the same cycle.
- Full queue: a same-cycle response does not re-enable issue that cycle, because can_issue uses the registered count. This is a decided one-cycle bubble.
- Response with empty queue: no in_r_valid_o bit is set, err_o <= 1 (sticky until clear/reset), count stays 0.
- Latency: zero added cycles on both request and response paths; no registers sit in the data path.
- busy_o = (count != 0), registered-state derived.

Test Plan:
- Single requester 0, addr 0x100, TCDM grants immediately, r_valid 1 cycle later with data 0xDEADBEEF -> in_gnt_o=0001 in cycle 0, in_r_valid_o=0001 with data 0xDEADBEEF in cycle 1, busy_o high exactly 1 cycle.
- All 4 requesters hold req, gnt always 1, 1-cycle responses -> grants rotate 0,1,2,3,0,...; each response routed to the requester granted the previous cycle; no ID mismatch over 100 cycles.
- MAX_OUTSTANDING=4, gnt=1, responses withheld -> exactly 4 grants, then out_req_o=0 while in_req_i held. Release one response -> out_req_o=1 next cycle.
- Requester 2 request with gnt=0 for 5 cycles while requester 3 also requests -> out_add_o stays at requester 2's address, pointer unchanged; on gnt, requester 2 is granted, then requester 3.
- Spurious out_r_valid_i with count=0 -> in_r_valid_o=0000, err_o=1 and stays 1; clear_i pulse -> err_o=0, count=0, pointer=0.
- Async reset asserted with 3 outstanding -> all state 0 immediately. Responses arriving after reset raise err_o, demonstrating the drop.
